// File: rtl/prefix_decoder.sv
// prefix_decoder: consumes 8086 prefix bytes ahead of each opcode and holds prefix state until retire
module prefix_decoder #(
  parameter int MAX_PREFIXES = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       next_instruction,
  input  logic       fifo_valid,
  input  logic [7:0] fifo_byte,
  output logic       fifo_rd_en,
  output logic       opcode_valid,
  output logic [7:0] opcode,
  input  logic       opcode_ack,
  output logic       seg_update,
  output logic       segment_override,
  output logic [1:0] override_in,
  output logic       rep,
  output logic       rep_z,
  output logic       lock,
  output logic [3:0] prefix_count
);
  typedef enum logic [1:0] {DECODE, OPCODE, EXEC} state_t;
  state_t     state_q, state_d;
  logic [7:0] opcode_q, opcode_d;
  logic       seg_update_q, seg_update_d;
  logic       seg_ov_q, seg_ov_d;
  logic [1:0] override_q, override_d;
  logic       rep_q, rep_d;
  logic       rep_z_q, rep_z_d;
  logic       lock_q, lock_d;
  logic [3:0] count_q, count_d;
  logic       take, clear, is_seg, is_rep, is_lock, is_prefix;
  // segment prefixes are 001s_s110; bits [4:3] encode ES/CS/SS/DS
  assign is_seg    = fifo_byte[7:5] == 3'b001 && fifo_byte[2:0] == 3'b110;
  assign is_rep    = fifo_byte[7:1] == 7'b1111_001;
  assign is_lock   = fifo_byte == 8'hF0;
  assign is_prefix = is_seg | is_rep | is_lock;
  assign take      = state_q == DECODE && fifo_valid && !flush;
  assign clear     = flush || (state_q == EXEC && next_instruction);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= DECODE;
      opcode_q     <= 8'h00;
      seg_update_q <= 1'b0;
      seg_ov_q     <= 1'b0;
      override_q   <= 2'd0;
      rep_q        <= 1'b0;
      rep_z_q      <= 1'b0;
      lock_q       <= 1'b0;
      count_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      seg_update_q <= seg_update_d;
      seg_ov_q     <= seg_ov_d;
      override_q   <= override_d;
      rep_q        <= rep_d;
      rep_z_q      <= rep_z_d;
      lock_q       <= lock_d;
      count_q      <= count_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    seg_update_d = 1'b0;
    seg_ov_d     = seg_ov_q;
    override_d   = override_q;
    rep_d        = rep_q;
    rep_z_d      = rep_z_q;
    lock_d       = lock_q;
    count_d      = count_q;
    if (clear) begin
      state_d    = DECODE;
      seg_ov_d   = 1'b0;
      override_d = 2'd0;
      rep_d      = 1'b0;
      rep_z_d    = 1'b0;
      lock_d     = 1'b0;
      count_d    = 4'd0;
    end else if (state_q == OPCODE) begin
      state_d = opcode_ack ? EXEC : OPCODE;
    end else if (take) begin
      count_d = is_prefix && count_q < 4'(MAX_PREFIXES) ? count_q + 4'd1 : count_q;
      if (is_seg) begin
        seg_update_d = 1'b1;
        seg_ov_d     = 1'b1;
        override_d   = fifo_byte[4:3];
      end
      if (is_rep) begin
        rep_d   = 1'b1;
        rep_z_d = fifo_byte[0];
      end
      if (is_lock) lock_d = 1'b1;
      if (!is_prefix) begin
        opcode_d = fifo_byte;
        state_d  = OPCODE;
      end
    end
  end
  always_comb begin
    fifo_rd_en       = take;
    opcode_valid     = state_q == OPCODE;
    opcode           = opcode_q;
    seg_update       = seg_update_q;
    segment_override = seg_ov_q;
    override_in      = override_q;
    rep              = rep_q;
    rep_z            = rep_z_q;
    lock             = lock_q;
    prefix_count     = count_q;
  end
endmodule

// File: tb/tb_prefix_decoder.sv
// tb_prefix_decoder: directed tests of prefix_decoder with hand-computed expectations
module tb_prefix_decoder;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic       next_instruction = 1'b0;
  logic       fifo_valid = 1'b0;
  logic [7:0] fifo_byte = 8'h00;
  logic       opcode_ack = 1'b0;
  logic       fifo_rd_en, opcode_valid, seg_update, segment_override, rep, rep_z, lock;
  logic [7:0] opcode;
  logic [1:0] override_in;
  logic [3:0] prefix_count;
  int total = 0;
  int bad = 0;

  prefix_decoder dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .next_instruction(next_instruction),
    .fifo_valid(fifo_valid), .fifo_byte(fifo_byte), .fifo_rd_en(fifo_rd_en),
    .opcode_valid(opcode_valid), .opcode(opcode), .opcode_ack(opcode_ack),
    .seg_update(seg_update), .segment_override(segment_override), .override_in(override_in),
    .rep(rep), .rep_z(rep_z), .lock(lock), .prefix_count(prefix_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_valid = 1'b1;
    fifo_byte  = b;
    tick();
    fifo_valid = 1'b0;
  endtask

  task automatic ack();
    opcode_ack = 1'b1;
    tick();
    opcode_ack = 1'b0;
  endtask

  task automatic retire();
    next_instruction = 1'b1;
    tick();
    next_instruction = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    total++; if ({fifo_rd_en, opcode_valid, seg_update, segment_override, rep, rep_z, lock} !== 7'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0", {fifo_rd_en, opcode_valid, seg_update, segment_override, rep, rep_z, lock}); end
    total++; if ({opcode, override_in, prefix_count} !== 14'h0) begin bad++; $display("FAIL reset_values got=%h exp=0", {opcode, override_in, prefix_count}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_segment();
    push(8'h2E);
    total++; if (seg_update !== 1'b1 || override_in !== 2'd1) begin bad++; $display("FAIL seg_2e got upd=%b ov=%0d exp upd=1 ov=1", seg_update, override_in); end
    push(8'h8B);
    total++; if (opcode_valid !== 1'b1 || opcode !== 8'h8B) begin bad++; $display("FAIL opcode_8b got v=%b op=%h exp v=1 op=8b", opcode_valid, opcode); end
    total++; if (prefix_count !== 4'd1 || segment_override !== 1'b1 || seg_update !== 1'b0) begin bad++; $display("FAIL prefix_8b got cnt=%0d so=%b upd=%b exp 1 1 0", prefix_count, segment_override, seg_update); end
    ack();
    retire();
  endtask

  task automatic test_multi_prefix();
    push(8'h26);
    total++; if (seg_update !== 1'b1 || override_in !== 2'd0) begin bad++; $display("FAIL seg_26 got upd=%b ov=%0d exp 1 0", seg_update, override_in); end
    push(8'h3E);
    total++; if (seg_update !== 1'b1 || override_in !== 2'd3) begin bad++; $display("FAIL seg_3e got upd=%b ov=%0d exp 1 3", seg_update, override_in); end
    push(8'hF3);
    total++; if (seg_update !== 1'b0 || rep !== 1'b1 || rep_z !== 1'b1) begin bad++; $display("FAIL rep_f3 got upd=%b rep=%b z=%b exp 0 1 1", seg_update, rep, rep_z); end
    push(8'hA4);
    total++; if (opcode !== 8'hA4 || prefix_count !== 4'd3 || override_in !== 2'd3) begin bad++; $display("FAIL opcode_a4 got op=%h cnt=%0d ov=%0d exp a4 3 3", opcode, prefix_count, override_in); end
    next_instruction = 1'b1;
    tick();
    next_instruction = 1'b0;
    total++; if (opcode_valid !== 1'b1 || rep !== 1'b1) begin bad++; $display("FAIL retire_in_opcode got v=%b rep=%b exp 1 1", opcode_valid, rep); end
    ack();
    total++; if (opcode_valid !== 1'b0 || rep !== 1'b1 || segment_override !== 1'b1) begin bad++; $display("FAIL exec_hold got v=%b rep=%b so=%b exp 0 1 1", opcode_valid, rep, segment_override); end
    retire();
    total++; if ({segment_override, override_in, rep, rep_z, lock, prefix_count} !== 10'b0) begin bad++; $display("FAIL retire_clear got=%b exp=0", {segment_override, override_in, rep, rep_z, lock, prefix_count}); end
  endtask

  task automatic test_saturate_and_hold();
    for (int i = 0; i < 20; i++) push(8'h26);
    total++; if (prefix_count !== 4'd15 || opcode_valid !== 1'b0) begin bad++; $display("FAIL saturate got cnt=%0d v=%b exp 15 0", prefix_count, opcode_valid); end
    push(8'h90);
    total++; if (opcode !== 8'h90 || opcode_valid !== 1'b1 || prefix_count !== 4'd15) begin bad++; $display("FAIL opcode_90 got op=%h v=%b cnt=%0d exp 90 1 15", opcode, opcode_valid, prefix_count); end
    fifo_valid = 1'b1;
    fifo_byte  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (opcode_valid !== 1'b1 || fifo_rd_en !== 1'b0 || opcode !== 8'h90) begin bad++; $display("FAIL hold_%0d got v=%b rd=%b op=%h exp 1 0 90", i, opcode_valid, fifo_rd_en, opcode); end
    end
    ack();
    total++; if (opcode_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin bad++; $display("FAIL exec_no_read got v=%b rd=%b exp 0 0", opcode_valid, fifo_rd_en); end
    fifo_valid = 1'b0;
    retire();
    total++; if (prefix_count !== 4'd0) begin bad++; $display("FAIL sat_clear got=%0d exp=0", prefix_count); end
  endtask

  task automatic test_flush();
    push(8'hF2);
    total++; if (rep !== 1'b1 || rep_z !== 1'b0) begin bad++; $display("FAIL rep_f2 got rep=%b z=%b exp 1 0", rep, rep_z); end
    fifo_valid = 1'b1;
    fifo_byte  = 8'h36;
    flush      = 1'b1;
    #1;
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL flush_rd got=%b exp=0", fifo_rd_en); end
    tick();
    flush = 1'b0;
    fifo_valid = 1'b0;
    total++; if ({seg_update, segment_override, rep, prefix_count} !== 7'b0) begin bad++; $display("FAIL flush_clear got=%b exp=0", {seg_update, segment_override, rep, prefix_count}); end
    fifo_valid = 1'b1;
    #1;
    total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL flush_decode got rd=%b exp=1", fifo_rd_en); end
    fifo_valid = 1'b0;
  endtask

  task automatic test_stall_and_async_reset();
    push(8'hF0);
    tick();
    tick();
    tick();
    total++; if (lock !== 1'b1 || prefix_count !== 4'd1 || opcode_valid !== 1'b0) begin bad++; $display("FAIL stall_lock got lk=%b cnt=%0d v=%b exp 1 1 0", lock, prefix_count, opcode_valid); end
    push(8'hF3);
    push(8'hF2);
    total++; if (rep_z !== 1'b0 || prefix_count !== 4'd3) begin bad++; $display("FAIL rep_last_wins got z=%b cnt=%0d exp 0 3", rep_z, prefix_count); end
    push(8'h36);
    push(8'hC3);
    ack();
    total++; if (override_in !== 2'd2 || lock !== 1'b1 || opcode !== 8'hC3) begin bad++; $display("FAIL exec_state got ov=%0d lk=%b op=%h exp 2 1 c3", override_in, lock, opcode); end
    reset_n = 1'b0;
    #1;
    total++; if ({fifo_rd_en, opcode_valid, seg_update, segment_override, rep, rep_z, lock, override_in, prefix_count, opcode} !== 21'b0) begin bad++; $display("FAIL async_reset got=%b exp=0", {fifo_rd_en, opcode_valid, seg_update, segment_override, rep, rep_z, lock, override_in, prefix_count, opcode}); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_segment();
    test_multi_prefix();
    test_saturate_and_hold();
    test_flush();
    test_stall_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
